// File: rtl/ysyx_22041412_axi_arbiter.sv
// ysyx_22041412_axi_arbiter: shares one AXI-bridge read channel between I and D caches and passes the D write channel through
module ysyx_22041412_axi_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_r_valid_i,
    input  logic [ADDR_WIDTH-1:0] i_r_addr_i,
    input  logic [7:0]            i_r_len_i,
    output logic                  i_r_ready_o,
    output logic                  i_r_last_o,
    output logic [DATA_WIDTH-1:0] i_r_data_o,
    input  logic                  d_r_valid_i,
    input  logic [ADDR_WIDTH-1:0] d_r_addr_i,
    input  logic [7:0]            d_r_len_i,
    output logic                  d_r_ready_o,
    output logic                  d_r_last_o,
    output logic [DATA_WIDTH-1:0] d_r_data_o,
    input  logic                  d_w_valid_i,
    input  logic [ADDR_WIDTH-1:0] d_w_addr_i,
    input  logic [7:0]            d_w_len_i,
    input  logic [2:0]            d_w_size_i,
    input  logic [DATA_WIDTH-1:0] d_w_data_i,
    output logic                  d_w_ready_o,
    output logic                  d_w_last_o,
    output logic                  r_valid_o,
    output logic [ADDR_WIDTH-1:0] r_addr_o,
    output logic [7:0]            r_len_o,
    input  logic                  r_ready_i,
    input  logic                  r_last_i,
    input  logic [DATA_WIDTH-1:0] r_data_i,
    output logic                  w_valid_o,
    output logic [ADDR_WIDTH-1:0] w_addr_o,
    output logic [7:0]            w_len_o,
    output logic [2:0]            w_size_o,
    output logic [DATA_WIDTH-1:0] w_data_o,
    input  logic                  w_ready_i,
    input  logic                  w_last_i,
    output logic [63:0]           i_grant_cnt,
    output logic [63:0]           d_grant_cnt,
    output logic [63:0]           conflict_cnt
);
    typedef enum logic [1:0] {R_IDLE, R_GNT_I, R_GNT_D} r_state_t;
    typedef enum logic {W_IDLE, W_BUSY} w_state_t;

    r_state_t r_state;
    w_state_t w_state;
    logic     last_gnt_d;
    logic     gnt_i;
    logic     gnt_d;
    logic     w_en;

    // Holding rst low drops any beat on the spot, so nothing leaks out during reset
    assign gnt_i = rst && (r_state == R_GNT_I);
    assign gnt_d = rst && (r_state == R_GNT_D);
    assign w_en  = rst && d_w_valid_i;

    // Read arbiter: decide only in idle, a tie goes to the side not served last, hold the grant until the final beat
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= R_IDLE;
            last_gnt_d   <= 1'b1;
            i_grant_cnt  <= '0;
            d_grant_cnt  <= '0;
            conflict_cnt <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (i_r_valid_i && (!d_r_valid_i || last_gnt_d)) begin
                        r_state      <= R_GNT_I;
                        last_gnt_d   <= 1'b0;
                        i_grant_cnt  <= i_grant_cnt + 64'd1;
                        conflict_cnt <= conflict_cnt + {63'd0, d_r_valid_i};
                    end else if (d_r_valid_i) begin
                        r_state      <= R_GNT_D;
                        last_gnt_d   <= 1'b1;
                        d_grant_cnt  <= d_grant_cnt + 64'd1;
                        conflict_cnt <= conflict_cnt + {63'd0, i_r_valid_i};
                    end
                end
                default: if (r_ready_i && r_last_i) r_state <= R_IDLE;
            endcase
        end
    end

    // Write burst tracker; a single-beat burst that completes in idle never enters busy
    always_ff @(posedge clk) begin
        if (!rst) w_state <= W_IDLE;
        else if (w_state == W_IDLE) w_state <= (d_w_valid_i && !(w_ready_i && w_last_i)) ? W_BUSY : W_IDLE;
        else if (w_ready_i && w_last_i) w_state <= W_IDLE;
    end

    assign r_valid_o   = gnt_i ? i_r_valid_i : gnt_d && d_r_valid_i;
    assign r_addr_o    = gnt_i ? i_r_addr_i : gnt_d ? d_r_addr_i : '0;
    assign r_len_o     = gnt_i ? i_r_len_i : gnt_d ? d_r_len_i : '0;
    assign i_r_ready_o = gnt_i && r_ready_i;
    assign i_r_last_o  = gnt_i && r_last_i;
    assign i_r_data_o  = gnt_i ? r_data_i : '0;
    assign d_r_ready_o = gnt_d && r_ready_i;
    assign d_r_last_o  = gnt_d && r_last_i;
    assign d_r_data_o  = gnt_d ? r_data_i : '0;
    assign w_valid_o   = w_en;
    assign w_addr_o    = w_en ? d_w_addr_i : '0;
    assign w_len_o     = w_en ? d_w_len_i : '0;
    assign w_size_o    = w_en ? d_w_size_i : '0;
    assign w_data_o    = w_en ? d_w_data_i : '0;
    assign d_w_ready_o = w_en && w_ready_i;
    assign d_w_last_o  = w_en && w_last_i;
endmodule

// File: tb/tb_ysyx_22041412_axi_arbiter.sv
// tb_ysyx_22041412_axi_arbiter: directed self-checking bench for the read arbiter and write pass-through
module tb_ysyx_22041412_axi_arbiter;
    logic        clk = 0;
    logic        rst = 0;
    logic        i_r_valid_i = 0, d_r_valid_i = 0, d_w_valid_i = 0;
    logic [31:0] i_r_addr_i = 0, d_r_addr_i = 0, d_w_addr_i = 0;
    logic [7:0]  i_r_len_i = 0, d_r_len_i = 0, d_w_len_i = 0;
    logic [2:0]  d_w_size_i = 0;
    logic [63:0] d_w_data_i = 0, r_data_i = 0;
    logic        r_ready_i = 0, r_last_i = 0, w_ready_i = 0, w_last_i = 0;
    logic        i_r_ready_o, i_r_last_o, d_r_ready_o, d_r_last_o, d_w_ready_o, d_w_last_o;
    logic [63:0] i_r_data_o, d_r_data_o, w_data_o;
    logic        r_valid_o, w_valid_o;
    logic [31:0] r_addr_o, w_addr_o;
    logic [7:0]  r_len_o, w_len_o;
    logic [2:0]  w_size_o;
    logic [63:0] i_grant_cnt, d_grant_cnt, conflict_cnt;
    int          n_checks = 0;
    int          n_fails = 0;

    ysyx_22041412_axi_arbiter dut (
        .clk(clk), .rst(rst),
        .i_r_valid_i(i_r_valid_i), .i_r_addr_i(i_r_addr_i), .i_r_len_i(i_r_len_i),
        .i_r_ready_o(i_r_ready_o), .i_r_last_o(i_r_last_o), .i_r_data_o(i_r_data_o),
        .d_r_valid_i(d_r_valid_i), .d_r_addr_i(d_r_addr_i), .d_r_len_i(d_r_len_i),
        .d_r_ready_o(d_r_ready_o), .d_r_last_o(d_r_last_o), .d_r_data_o(d_r_data_o),
        .d_w_valid_i(d_w_valid_i), .d_w_addr_i(d_w_addr_i), .d_w_len_i(d_w_len_i),
        .d_w_size_i(d_w_size_i), .d_w_data_i(d_w_data_i),
        .d_w_ready_o(d_w_ready_o), .d_w_last_o(d_w_last_o),
        .r_valid_o(r_valid_o), .r_addr_o(r_addr_o), .r_len_o(r_len_o),
        .r_ready_i(r_ready_i), .r_last_i(r_last_i), .r_data_i(r_data_i),
        .w_valid_o(w_valid_o), .w_addr_o(w_addr_o), .w_len_o(w_len_o),
        .w_size_o(w_size_o), .w_data_o(w_data_o),
        .w_ready_i(w_ready_i), .w_last_i(w_last_i),
        .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 0;
        tick();
        rst = 1;
    endtask

    initial begin
        tick();
        tick();
        #1;
        chk("rst_r_valid", r_valid_o, 0);
        chk("rst_w_valid", w_valid_o, 0);
        chk("rst_cnt", i_grant_cnt | d_grant_cnt | conflict_cnt, 0);
        chk("rst_state", dut.r_state, 0);
        rst = 1;
        // Lone I read, len 3
        i_r_valid_i = 1; i_r_addr_i = 32'h8000_0000; i_r_len_i = 3;
        #1 chk("i_req_same_cycle", r_valid_o, 0);
        tick();
        chk("i_r_valid", r_valid_o, 1);
        chk("i_r_addr", r_addr_o, 64'h8000_0000);
        chk("i_r_len", r_len_o, 3);
        chk("i_gnt_cnt", i_grant_cnt, 1);
        for (int b = 0; b < 4; b++) begin
            r_ready_i = 1; r_last_i = (b == 3); r_data_i = 64'h100 + b;
            #1;
            chk("i_beat_ready", i_r_ready_o, 1);
            chk("i_beat_data", i_r_data_o, 64'h100 + b);
            chk("i_beat_last", i_r_last_o, (b == 3));
            chk("i_beat_d_ready", d_r_ready_o, 0);
            chk("i_beat_d_data", d_r_data_o, 0);
            tick();
        end
        r_ready_i = 0; r_last_i = 0; i_r_valid_i = 0;
        #1;
        chk("i_done_valid", r_valid_o, 0);
        chk("i_done_state", dut.r_state, 0);
        // Simultaneous requests out of reset: I first, then D
        do_reset();
        i_r_valid_i = 1; i_r_addr_i = 32'h1000; i_r_len_i = 0;
        d_r_valid_i = 1; d_r_addr_i = 32'h2000; d_r_len_i = 1;
        tick();
        chk("tie_first_addr", r_addr_o, 32'h1000);
        chk("tie_conflict", conflict_cnt, 1);
        r_ready_i = 1; r_last_i = 1; r_data_i = 64'hAA;
        #1;
        chk("tie_i_ready", i_r_ready_o, 1);
        chk("tie_d_ready", d_r_ready_o, 0);
        tick();
        r_ready_i = 0; r_last_i = 0; i_r_valid_i = 0;
        #1;
        chk("tie_bubble_valid", r_valid_o, 0);
        chk("tie_bubble_state", dut.r_state, 0);
        tick();
        chk("tie_d_addr", r_addr_o, 32'h2000);
        chk("tie_d_len", r_len_o, 1);
        for (int b = 0; b < 2; b++) begin
            r_ready_i = 1; r_last_i = (b == 1); r_data_i = 64'hD0 + b;
            #1;
            chk("tie_d_data", d_r_data_o, 64'hD0 + b);
            chk("tie_d_last", d_r_last_o, (b == 1));
            tick();
        end
        r_ready_i = 0; r_last_i = 0; d_r_valid_i = 0;
        #1;
        chk("tie_i_cnt", i_grant_cnt, 1);
        chk("tie_d_cnt", d_grant_cnt, 1);
        chk("tie_conf_cnt", conflict_cnt, 1);
        // Six contended single-beat bursts alternate I, D, ...
        do_reset();
        i_r_valid_i = 1; d_r_valid_i = 1; i_r_addr_i = 32'h1000; d_r_addr_i = 32'h2000;
        i_r_len_i = 0; d_r_len_i = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            r_ready_i = 1; r_last_i = 1;
            #1;
            chk("alt_addr", r_addr_o, (k % 2 == 0) ? 32'h1000 : 32'h2000);
            tick();
            r_ready_i = 0; r_last_i = 0;
            #1;
            chk("alt_bubble", r_valid_o, 0);
        end
        i_r_valid_i = 0; d_r_valid_i = 0;
        chk("alt_conflict", conflict_cnt, 6);
        chk("alt_i_cnt", i_grant_cnt, 3);
        chk("alt_d_cnt", d_grant_cnt, 3);
        // D write burst concurrent with I read burst
        do_reset();
        i_r_valid_i = 1; i_r_addr_i = 32'h8000_0100; i_r_len_i = 7;
        tick();
        d_w_valid_i = 1; d_w_addr_i = 32'h3000; d_w_len_i = 7; d_w_size_i = 3;
        for (int k = 0; k < 8; k++) begin
            r_ready_i = 1; r_last_i = (k == 7); r_data_i = 64'h500 + k;
            w_ready_i = 1; w_last_i = (k == 7); d_w_data_i = 64'h700 + 3 * k;
            #1;
            chk("wr_valid", w_valid_o, 1);
            chk("wr_addr", w_addr_o, 32'h3000);
            chk("wr_len_size", {w_len_o, w_size_o}, {8'd7, 3'd3});
            chk("wr_data", w_data_o, 64'h700 + 3 * k);
            chk("wr_ready_last", {d_w_ready_o, d_w_last_o}, {1'b1, k == 7});
            chk("wr_i_data", i_r_data_o, 64'h500 + k);
            if (k > 0) chk("wr_busy", dut.w_state, 1);
            tick();
        end
        r_ready_i = 0; r_last_i = 0; w_ready_i = 0; w_last_i = 0;
        i_r_valid_i = 0; d_w_valid_i = 0;
        #1;
        chk("wr_idle", dut.w_state, 0);
        chk("wr_r_idle", dut.r_state, 0);
        chk("wr_off", w_valid_o, 0);
        // Reset on second beat of a D read
        d_r_valid_i = 1; d_r_addr_i = 32'h4000; d_r_len_i = 3;
        tick();
        chk("mr_d_cnt", d_grant_cnt, 1);
        r_ready_i = 1;
        tick();
        rst = 0;
        #1;
        chk("mr_beat_dropped", d_r_ready_o, 0);
        tick();
        chk("mr_valid", r_valid_o, 0);
        chk("mr_cnts", i_grant_cnt | d_grant_cnt | conflict_cnt, 0);
        chk("mr_state", dut.r_state, 0);
        rst = 1; d_r_valid_i = 0; r_ready_i = 0;
        i_r_valid_i = 1; i_r_addr_i = 32'h5000; i_r_len_i = 0;
        tick();
        chk("mr_i_valid", r_valid_o, 1);
        chk("mr_i_cnt", i_grant_cnt, 1);
        r_ready_i = 1; r_last_i = 1;
        tick();
        r_ready_i = 0; r_last_i = 0; i_r_valid_i = 0;
        tick();
        // D drops valid after beat 1 of len 3
        d_r_valid_i = 1; d_r_addr_i = 32'h6000; d_r_len_i = 3;
        tick();
        r_ready_i = 1;
        tick();
        d_r_valid_i = 0; r_ready_i = 0;
        #1;
        chk("drop_valid", r_valid_o, 0);
        chk("drop_state", dut.r_state, 2);
        tick();
        chk("drop_hold", dut.r_state, 2);
        for (int b = 1; b < 4; b++) begin
            r_ready_i = 1; r_last_i = (b == 3); r_data_i = 64'h900 + b;
            #1;
            chk("drop_fwd", d_r_data_o, 64'h900 + b);
            tick();
        end
        r_ready_i = 0; r_last_i = 0;
        #1;
        chk("drop_idle", dut.r_state, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/ysyx_22041412_axi_arbiter.md
# ysyx_22041412_axi_arbiter

Shares the single downstream AXI-bridge read channel between the instruction-fetch cache (I side, read-only) and the data cache (D side, read and write). Read bursts are granted whole: the selected requester owns the channel from request to final beat. The D-side write channel passes through with burst tracking. The block sits between both caches and the AXI master bridge, and exports grant and conflict counters for the performance monitor.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 64, data beat width

Ports (the same protocol applies upstream and downstream: valid holds for the whole burst, ready pulses once per beat, last accompanies the final beat):
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- i_r_valid_i  in  1  I-side read request
- i_r_addr_i  in  ADDR_WIDTH  I-side read address
- i_r_len_i  in  8  I-side burst length-1
- i_r_ready_o  out  1  I-side beat valid
- i_r_last_o  out  1  I-side final beat
- i_r_data_o  out  DATA_WIDTH  I-side read data
- d_r_valid_i, d_r_addr_i, d_r_len_i, d_r_ready_o, d_r_last_o, d_r_data_o  same as the I-side ports, for D-side reads
- d_w_valid_i  in  1  D-side write request
- d_w_addr_i  in  ADDR_WIDTH  D-side write address
- d_w_len_i  in  8  D-side write burst length-1
- d_w_size_i  in  3  D-side write size
- d_w_data_i  in  DATA_WIDTH  D-side write data
- d_w_ready_o  out  1  D-side write beat accepted
- d_w_last_o  out  1  D-side write final beat
- r_valid_o, r_addr_o, r_len_o  out  1/ADDR_WIDTH/8  downstream read request
- r_ready_i, r_last_i, r_data_i  in  1/1/DATA_WIDTH  downstream read beat
- w_valid_o, w_addr_o, w_len_o, w_size_o, w_data_o  out  downstream write request
- w_ready_i, w_last_i  in  1  downstream write beat and final beat
- i_grant_cnt, d_grant_cnt, conflict_cnt  out  64  performance counters

## Operation
Read FSM states: R_IDLE, R_GNT_I, R_GNT_D.

- **R_IDLE:**
  - If only i_r_valid_i is set, go to R_GNT_I. If only d_r_valid_i is set, go to R_GNT_D.
  - If both are set, grant the side not recorded in last_gnt, and increment conflict_cnt.
  - On every transition into a grant state: last_gnt takes the new grantee, and the matching grant counter increments by 1.
- **R_GNT_x:**
  - r_valid_o = x_r_valid_i.
  - r_addr_o and r_len_o are muxed from side x.
  - r_data_i is routed to x_r_data_o. x_r_ready_o = r_ready_i and x_r_last_o = r_last_i.
  - The non-granted side sees ready=0, last=0, data=0.
- **Leaving R_GNT_x:** when r_ready_i && r_last_i, go to R_IDLE. The transition is unconditional and ignores whether the requester's valid is still set.
- **Valid dropped mid-burst:** this is a requester protocol violation. The FSM stays in its grant state until the final beat; beats still forward, r_valid_o follows the requester's valid.
- **last_gnt reset value:** D, so the first tie goes to I.

Write FSM states: W_IDLE, W_BUSY.

- **W_IDLE:** d_w_valid_i → W_BUSY.
- **Pass-through:** in both states, downstream w_* = d_w_* and d_w_ready_o/d_w_last_o = w_ready_i/w_last_i, gated by d_w_valid_i.
- **W_BUSY:** w_ready_i && w_last_i → W_IDLE.
- **Channel independence:** the write path never blocks reads, and reads never block writes.

Counters:
- All three counters are 64-bit, reset to 0, and wrap modulo 2^64.

## Timing
- **Reset (rst=0 at a clock edge):**
  - Both FSMs go to IDLE and last_gnt=D.
  - Counters clear.
  - All outputs are 0 in the cycle after reset, including mid-burst. Beats arriving during reset are dropped.
- **Request latency:** one cycle. A request seen in R_IDLE at edge n gives r_valid_o=1 from cycle n+1.
- **Forwarding:** beats forward combinationally with zero added latency.
- **Burst-to-burst gap:** after the final beat, at least one R_IDLE cycle follows before the next grant. Back-to-back bursts therefore have a 1-cycle bubble.
- **Arbitration instant:** the decision is made only in R_IDLE. A request arriving during a grant waits, unaffected by others.
- **Single-beat burst:** r_len_o=0 with r_last_i on the first ready behaves identically.
- **Write path:** no registered latency. W_BUSY exists for monitoring and reset cleanup only.

## Test plan
- **Lone I read:** i_r_valid_i with addr 0x80000000, len 3. Response: r_valid_o=1 the next cycle with the same addr/len; 4 beats route to I; d_r_ready_o stays 0; i_grant_cnt=1.
- **Simultaneous I and D requests out of reset:**
  - Expected grant order: I first, then D after a 1-cycle R_IDLE.
  - Expected counters: conflict_cnt=1, i_grant_cnt=1, d_grant_cnt=1.
- **Both sides requesting continuously for 6 bursts:** grants alternate I, D, I, D, I, D; conflict_cnt=6.
- **D write during an I read burst:**
  - Stimulus: d_w_valid_i issues a len-7 burst while an I read burst is in progress.
  - Response: both progress concurrently; w_* mirrors the inputs; the write FSM returns to W_IDLE on w_last_i.
- **Reset mid-burst:** rst=0 on the second beat of a D read. Response: the next cycle shows r_valid_o=0, all counters 0, and R_IDLE; a subsequent I request is granted normally.
- **Requester drops valid mid-burst:** d_r_valid_i deasserts after beat 1 of len 3. Response: the FSM stays in R_GNT_D until r_last_i, then returns to R_IDLE.
